// File: rtl/ps2_host_cmd_seq.sv
// ============================================================================
// Module      : ps2_host_cmd_seq
// Description : Host-side PS/2 command sequencer. Arbitrates keyboard init
//               (FF + BAT) and LED update (ED + LED byte) over one transmitter,
//               handles FA/FE/timeouts and forwards other rx bytes as scancodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_cmd_seq #(
  parameter logic [31:0] ACK_TIMEOUT = 32'd2_000_000,
  parameter logic [31:0] BAT_TIMEOUT = 32'd100_000_000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_bits,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       kb_ready,
  output logic       scan_valid,
  output logic [7:0] scan_data
);

  localparam logic [7:0] C_CMD_RESET = 8'hFF;
  localparam logic [7:0] C_CMD_LED   = 8'hED;
  localparam logic [7:0] C_ACK       = 8'hFA;
  localparam logic [7:0] C_RESEND    = 8'hFE;
  localparam logic [7:0] C_BAT_OK    = 8'hAA;
  localparam logic [7:0] C_BAT_FAIL  = 8'hFC;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WAIT_BAT = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  // Which byte of which command is currently in flight
  typedef enum logic [1:0] {
    B_RESET   = 2'd0,
    B_LED_CMD = 2'd1,
    B_LED_ARG = 2'd2
  } phase_t;

  state_t      r_state,    w_state_nx;
  phase_t      r_phase,    w_phase_nx;
  logic [7:0]  r_byte,     w_byte_nx;
  logic [31:0] r_timer,    w_timer_nx;
  logic [1:0]  r_retry,    w_retry_nx;
  logic        r_busy,     w_busy_nx;
  logic        r_kb_ready, w_kb_ready_nx;
  logic        r_pend_init;
  logic        r_pend_led;
  logic [2:0]  r_led_bits;
  logic        r_scan_valid;
  logic [7:0]  r_scan_data;
  logic        w_clr_init;
  logic        w_clr_led;
  logic        w_consume;

  always_comb begin
    w_state_nx    = r_state;
    w_phase_nx    = r_phase;
    w_byte_nx     = r_byte;
    w_timer_nx    = r_timer;
    w_retry_nx    = r_retry;
    w_busy_nx     = r_busy;
    w_kb_ready_nx = r_kb_ready;
    w_clr_init    = 1'b0;
    w_clr_led     = 1'b0;
    w_consume     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend_init) begin
          w_clr_init    = 1'b1;
          w_kb_ready_nx = 1'b0;
          w_phase_nx    = B_RESET;
          w_byte_nx     = C_CMD_RESET;
          w_retry_nx    = 2'd0;
          w_busy_nx     = 1'b1;
          w_state_nx    = S_SEND;
        end else if (r_pend_led) begin
          w_clr_led     = 1'b1;
          w_phase_nx    = B_LED_CMD;
          w_byte_nx     = C_CMD_LED;
          w_retry_nx    = 2'd0;
          w_busy_nx     = 1'b1;
          w_state_nx    = S_SEND;
        end
      end

      S_SEND: begin
        w_timer_nx = 32'd0;
        w_state_nx = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        w_timer_nx = r_timer + 32'd1;
        if (rx_valid && rx_data == C_ACK) begin
          w_consume = 1'b1;
          case (r_phase)
            B_LED_CMD: begin
              w_byte_nx  = {5'b0, r_led_bits};
              w_phase_nx = B_LED_ARG;
              w_retry_nx = 2'd0;
              w_state_nx = S_SEND;
            end
            B_RESET: begin
              w_timer_nx = 32'd0;
              w_state_nx = S_WAIT_BAT;
            end
            default: w_state_nx = S_DONE;
          endcase
        end else if ((rx_valid && rx_data == C_RESEND) ||
                     r_timer == ACK_TIMEOUT - 32'd1) begin
          w_consume = rx_valid && rx_data == C_RESEND;
          if (r_retry < MAX_RETRY) begin
            w_retry_nx = r_retry + 2'd1;
            w_state_nx = S_SEND;
          end else begin
            w_state_nx = S_ERR;
          end
        end
      end

      S_WAIT_BAT: begin
        w_timer_nx = r_timer + 32'd1;
        if (rx_valid && rx_data == C_BAT_OK) begin
          w_consume     = 1'b1;
          w_kb_ready_nx = 1'b1;
          w_state_nx    = S_DONE;
        end else if (rx_valid && rx_data == C_BAT_FAIL) begin
          w_consume  = 1'b1;
          w_state_nx = S_ERR;
        end else if (r_timer == BAT_TIMEOUT - 32'd1) begin
          w_state_nx = S_ERR;
        end
      end

      S_DONE: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end

      S_ERR: begin
        w_busy_nx = 1'b0;
        if (r_phase == B_RESET) w_kb_ready_nx = 1'b0;
        w_state_nx = S_IDLE;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_phase      <= B_RESET;
      r_byte       <= 8'd0;
      r_timer      <= 32'd0;
      r_retry      <= 2'd0;
      r_busy       <= 1'b0;
      r_kb_ready   <= 1'b0;
      r_pend_init  <= 1'b0;
      r_pend_led   <= 1'b0;
      r_led_bits   <= 3'd0;
      r_scan_valid <= 1'b0;
      r_scan_data  <= 8'd0;
    end else begin
      r_state      <= w_state_nx;
      r_phase      <= w_phase_nx;
      r_byte       <= w_byte_nx;
      r_timer      <= w_timer_nx;
      r_retry      <= w_retry_nx;
      r_busy       <= w_busy_nx;
      r_kb_ready   <= w_kb_ready_nx;
      // A request arriving in the same cycle it is accepted stays pending
      r_pend_init  <= (r_pend_init & ~w_clr_init) | init_req;
      r_pend_led   <= (r_pend_led & ~w_clr_led) | led_req;
      if (led_req) r_led_bits <= led_bits;
      r_scan_valid <= rx_valid & ~w_consume;
      if (rx_valid) r_scan_data <= rx_data;
    end
  end

  assign tx_en      = (r_state == S_SEND);
  assign tx_data    = r_byte;
  assign busy       = r_busy;
  assign cmd_done   = (r_state == S_DONE);
  assign cmd_err    = (r_state == S_ERR);
  assign kb_ready   = r_kb_ready;
  assign scan_valid = r_scan_valid;
  assign scan_data  = r_scan_data;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_cmd_seq.sv
// ============================================================================
// Module      : tb_ps2_host_cmd_seq
// Description : Self-checking bench for ps2_host_cmd_seq with a scripted
//               keyboard responder and a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_cmd_seq;

  localparam logic [31:0] ACK_TO = 32'd20;
  localparam logic [31:0] BAT_TO = 32'd60;
  localparam int          MAXR   = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       init_req = 1'b0, led_req = 1'b0;
  logic [2:0] led_bits = 3'd0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data, scan_data;
  logic       tx_en, busy, cmd_done, cmd_err, kb_ready, scan_valid;

  ps2_host_cmd_seq #(.ACK_TIMEOUT(ACK_TO), .BAT_TIMEOUT(BAT_TO), .MAX_RETRY(2'd3)) dut (
    .clk(clk), .rstn(rstn), .init_req(init_req), .led_req(led_req), .led_bits(led_bits),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_en(tx_en), .busy(busy),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .kb_ready(kb_ready),
    .scan_valid(scan_valid), .scan_data(scan_data)
  );

  always #5 clk = ~clk;

  // resp: nibble i = keyboard answer to i-th transmission (1=FA, 2=FE, 3=silence)
  // bat : 0=AA, 1=FC, 2=silence
  typedef struct {
    bit          is_init;
    logic [2:0]  led;
    bit          noise;
    logic [31:0] resp;
    logic [1:0]  bat;
    int          exp_n;
    logic [63:0] exp_bytes;
    bit          exp_done;
    bit          exp_kb;
  } vec_t;

  typedef struct {
    int         at;
    logic [7:0] b;
  } sched_t;

  vec_t vecs[$];
  int   n_pass = 0, n_total = 0;
  bit   kb_model = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Command outcome from the keyboard's replies: each byte may be sent up to MAXR+1 times
  function automatic void model(inout vec_t v, inout bit kb);
    logic [7:0] seq[$];
    int a = 0;
    bit ok = 1'b1;
    v.exp_n = 0;
    v.exp_bytes = 64'd0;
    if (v.is_init) seq.push_back(8'hFF);
    else begin seq.push_back(8'hED); seq.push_back({5'b0, v.led}); end
    foreach (seq[j]) begin
      bit acked = 1'b0;
      if (ok) begin
        for (int t = 0; t <= MAXR && !acked; t++) begin
          v.exp_bytes[8*v.exp_n +: 8] = seq[j];
          v.exp_n++;
          if (((v.resp >> (4*a)) & 32'hF) == 32'd1) acked = 1'b1;
          a++;
        end
        if (!acked) ok = 1'b0;
      end
    end
    if (ok && v.is_init) ok = (v.bat == 2'd0);
    if (v.is_init) kb = ok;
    v.exp_done = ok;
    v.exp_kb   = kb;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] act[$];
    sched_t     q[$];
    int         k = 0, cyc = 0, rd;
    bit         fin = 1'b0, got_done = 1'b0, drv_prev = 1'b0;
    logic [7:0] last_drv = 8'd0;
    logic [31:0] nib;
    @(negedge clk);
    if (v.is_init) init_req = 1'b1;
    else begin led_req = 1'b1; led_bits = v.led; end
    @(negedge clk);
    init_req = 1'b0;
    led_req  = 1'b0;
    while (!fin && cyc < 2000) begin
      if (drv_prev) begin
        chk({tag, " scan_valid"}, scan_valid, last_drv == 8'h1D);
        if (last_drv == 8'h1D) chk({tag, " scan_data"}, scan_data, 8'h1D);
      end
      if (tx_en) begin
        act.push_back(tx_data);
        nib = (v.resp >> (4*k)) & 32'hF;
        rd  = $urandom_range(2, 5);
        if (v.noise && k == 0) q.push_back('{cyc + 1, 8'h1D});
        if (nib == 32'd1) begin
          q.push_back('{cyc + rd, 8'hFA});
          if (tx_data == 8'hFF && v.bat != 2'd2)
            q.push_back('{cyc + rd + $urandom_range(3, 8), (v.bat == 2'd0) ? 8'hAA : 8'hFC});
        end else if (nib == 32'd2) begin
          q.push_back('{cyc + rd, 8'hFE});
        end
        k++;
      end
      if (cmd_done) begin got_done = 1'b1; fin = 1'b1; end
      if (cmd_err) fin = 1'b1;
      drv_prev = 1'b0;
      rx_valid = 1'b0;
      if (q.size() > 0 && q[0].at == cyc) begin
        rx_valid = 1'b1;
        rx_data  = q[0].b;
        last_drv = q[0].b;
        drv_prev = 1'b1;
        void'(q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    rx_valid = 1'b0;
    chk({tag, " finished"}, fin, 1'b1);
    chk({tag, " n_sent"}, act.size(), v.exp_n);
    for (int i = 0; i < act.size() && i < v.exp_n; i++)
      chk($sformatf("%s byte%0d", tag, i), act[i], v.exp_bytes[8*i +: 8]);
    chk({tag, " done_vs_err"}, got_done, v.exp_done);
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " kb_ready"}, kb_ready, v.exp_kb);
  endtask

  initial begin
    vec_t v;
    int   cnt;
    vecs.push_back('{1'b1, 3'd0, 1'b0, 32'h1,     2'd0, 1, 64'hFF,         1'b1, 1'b1});
    vecs.push_back('{1'b0, 3'b101, 1'b0, 32'h11,  2'd0, 2, 64'h05ED,       1'b1, 1'b1});
    vecs.push_back('{1'b0, 3'b000, 1'b0, 32'h2222, 2'd0, 4, 64'hEDEDEDED,  1'b0, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 32'h3333,  2'd0, 4, 64'hFFFFFFFF,   1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 1'b1, 32'h11,  2'd0, 2, 64'h03ED,       1'b1, 1'b0});
    vecs.push_back('{1'b0, 3'b110, 1'b0, 32'h1312, 2'd0, 4, 64'h0606EDED,  1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 1'b1, 32'h12,    2'd0, 2, 64'hFFFF,       1'b1, 1'b1});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 32'h1,     2'd1, 1, 64'hFF,         1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b111, 1'b0, 32'h22221, 2'd0, 5, 64'h07070707ED, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'd0, 1'b0, 32'h1,     2'd2, 1, 64'hFF,         1'b0, 1'b0});

    #3;
    chk("reset tx_en", tx_en, 1'b0);
    chk("reset outputs", {busy, cmd_done, cmd_err, kb_ready, scan_valid, tx_data, scan_data}, 21'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // FA outside any wait state is ordinary data
    rx_valid = 1'b1; rx_data = 8'hFA;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("idle_fa scan_valid", scan_valid, 1'b1);
    chk("idle_fa scan_data", scan_data, 8'hFA);
    chk("idle_fa no_tx", tx_en, 1'b0);

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("dir%0d", i));
      kb_model = vecs[i].exp_kb;
    end

    for (int r = 0; r < 20; r++) begin
      v.is_init = ($urandom_range(0, 2) == 0);
      v.led     = 3'($urandom_range(0, 7));
      v.noise   = ($urandom_range(0, 1) == 1);
      v.resp    = 32'd0;
      for (int a = 0; a < 8; a++) begin
        int p = $urandom_range(0, 19);
        v.resp[4*a +: 4] = (p < 12) ? 4'd1 : (p < 17) ? 4'd2 : 4'd3;
      end
      v.bat = (($urandom_range(0, 9)) < 7) ? 2'd0 : (($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2);
      model(v, kb_model);
      run_vec(v, $sformatf("rnd%0d", r));
    end

    // Simultaneous requests: init goes first; reset during BAT wait cancels everything
    @(negedge clk);
    init_req = 1'b1; led_req = 1'b1; led_bits = 3'b010;
    @(negedge clk);
    init_req = 1'b0; led_req = 1'b0;
    cnt = 0;
    while (!tx_en && cnt < 50) begin @(negedge clk); cnt++; end
    chk("both first_tx_en", tx_en, 1'b1);
    chk("both first_byte", tx_data, 8'hFF);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hFA;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("bat_wait busy", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst outputs", {tx_en, busy, cmd_done, cmd_err, kb_ready, scan_valid, tx_data, scan_data},
        22'd0);
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (tx_en || busy || cmd_done || cmd_err) cnt++;
    end
    chk("after_rst no_activity", cnt, 0);
    chk("after_rst kb_ready", kb_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
